// File: rtl/fifo_seq_pkg.sv
// Shared state encoding and default sizing for the FIFO write/read sequencer.
package fifo_seq_pkg;

  localparam int DW_DEF     = 8;
  localparam int DEPTH_DEF  = 256;
  localparam int SETTLE_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SETTLE,
    READ,
    DRAIN
  } seq_state_e;

endpackage

// File: rtl/fifo_rd_check.sv
// Read-back checker: aligns compares to the cycle after each read strobe
// and latches any data mismatch until reset.
module fifo_rd_check
  import fifo_seq_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int IW = $clog2(DEPTH_DEF) + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          i_rd_en,
  input  logic [DW-1:0] i_rd_data,
  input  logic [7:0]    i_round_cnt,
  input  logic          i_clr,
  output logic          o_err_flag
);

  logic          r_rd_en_d;
  logic [IW-1:0] r_cmp_idx;
  logic          r_err;
  logic [DW-1:0] w_exp;
  logic          w_cmp_bad;

  assign w_exp     = DW'(r_cmp_idx) + DW'(i_round_cnt);
  assign w_cmp_bad = r_rd_en_d && (i_rd_data != w_exp);

  // Clear wins over the final increment so the next round starts at index 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_en_d <= 1'b0;
      r_cmp_idx <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rd_en_d <= i_rd_en;
      if (i_clr)          r_cmp_idx <= '0;
      else if (r_rd_en_d) r_cmp_idx <= r_cmp_idx + 1'b1;
      if (w_cmp_bad)      r_err     <= 1'b1;
    end
  end

  assign o_err_flag = r_err;

endmodule

// File: rtl/fifo_seq_ctrl.sv
// FIFO exerciser: fills the FIFO with an incrementing pattern offset by the
// round count, waits for the flags to settle, reads it back and checks it.
module fifo_seq_ctrl
  import fifo_seq_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          fifo_wr_en,
  output logic [DW-1:0] fifo_wr_data,
  output logic          fifo_rd_en,
  output logic          err_flag,
  output logic [7:0]    round_cnt,
  output logic          busy
);

  localparam int            IW      = $clog2(DEPTH) + 1;
  localparam int            SW      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [IW-1:0] IDX_LST = IW'(DEPTH - 1);
  localparam logic [IW-1:0] IDX_END = IW'(DEPTH);

  seq_state_e    r_state, w_state_nxt;
  logic [IW-1:0] r_wr_idx, r_rd_idx;
  logic [SW-1:0] r_settle_cnt;
  logic [7:0]    r_round_cnt;
  logic          w_wr_en, w_rd_en, w_settle_done, w_clr;

  assign w_settle_done = (r_settle_cnt == SW'(SETTLE_CYC - 1));
  assign w_clr         = (r_state == DRAIN);

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      IDLE:   if (fifo_empty) w_state_nxt = WRITE;
      WRITE: begin
        w_wr_en = !fifo_full && (r_wr_idx < IDX_END);
        if (w_wr_en && r_wr_idx == IDX_LST) w_state_nxt = SETTLE;
      end
      SETTLE: if (w_settle_done) w_state_nxt = READ;
      READ: begin
        // An early empty only stalls; the read count alone ends the phase.
        w_rd_en = !fifo_empty && (r_rd_idx < IDX_END);
        if (w_rd_en && r_rd_idx == IDX_LST) w_state_nxt = DRAIN;
      end
      DRAIN:  w_state_nxt = WRITE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= IDLE;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_settle_cnt <= '0;
      r_round_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_en) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_rd_en) r_rd_idx <= r_rd_idx + 1'b1;
      if (r_state == SETTLE)
        r_settle_cnt <= w_settle_done ? '0 : r_settle_cnt + 1'b1;
      if (r_state == DRAIN) begin
        r_wr_idx    <= '0;
        r_rd_idx    <= '0;
        r_round_cnt <= r_round_cnt + 1'b1;
      end
    end
  end

  fifo_rd_check #(
    .DW (DW),
    .IW (IW)
  ) u_rd_check (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .i_rd_en     (w_rd_en),
    .i_rd_data   (fifo_rd_data),
    .i_round_cnt (r_round_cnt),
    .i_clr       (w_clr),
    .o_err_flag  (err_flag)
  );

  assign fifo_wr_en   = w_wr_en;
  assign fifo_rd_en   = w_rd_en;
  assign fifo_wr_data = DW'(r_wr_idx) + DW'(r_round_cnt);
  assign round_cnt    = r_round_cnt;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_fifo_seq_ctrl.sv
// Directed bench for fifo_seq_ctrl against an ideal 256-word FIFO model.
module tb_fifo_seq_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       fifo_wr_en, fifo_rd_en, err_flag, busy;
  logic [7:0] fifo_wr_data, round_cnt;

  fifo_seq_ctrl #(.DW(8), .DEPTH(256), .SETTLE_CYC(2)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .fifo_rd_en   (fifo_rd_en),
    .err_flag     (err_flag),
    .round_cnt    (round_cnt),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // ideal FIFO: flags track occupancy with no lag, show-ahead off
  logic [7:0] mem [0:255];
  int  wp = 0, rp = 0, cnt = 0, corrupt_idx = -1;
  logic force_full = 1'b0, flush = 1'b0;
  assign fifo_full  = (cnt == 256) || force_full;
  assign fifo_empty = (cnt == 0);

  always @(posedge sys_clk) begin
    if (flush) begin
      wp <= 0; rp <= 0; cnt <= 0;
    end else begin
      if (fifo_wr_en && cnt < 256) begin
        mem[wp] <= fifo_wr_data;
        wp <= (wp + 1) % 256;
      end
      if (fifo_rd_en && cnt > 0) begin
        fifo_rd_data <= mem[rp] ^ ((rp == corrupt_idx) ? 8'h01 : 8'h00);
        rp <= (rp + 1) % 256;
      end
      cnt <= cnt + ((fifo_wr_en && cnt < 256) ? 1 : 0) - ((fifo_rd_en && cnt > 0) ? 1 : 0);
    end
  end

  int n_cmp = 0, n_bad = 0, cyc = 0, proto_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_wr_en"},   fifo_wr_en,   0);
    chk({tag, "_rd_en"},   fifo_rd_en,   0);
    chk({tag, "_wr_data"}, fifo_wr_data, 0);
    chk({tag, "_err"},     err_flag,     0);
    chk({tag, "_round"},   round_cnt,    0);
    chk({tag, "_busy"},    busy,         0);
  endtask

  // Called at a negedge; returns at the negedge where round_cnt has stepped
  // (that cycle's write belongs to the next round) or right after an abort.
  task automatic run_round(input int rnd, input int stall_at, input int corrupt_at,
                           input int abort_at, input bit exp_err);
    int nwr = 0, nrd = 0, wbad = 0, gap = 0, last_rd = 0, inc_cyc = 0;
    int rdc = -1, stall_left = 0, stall_wr = 0;
    bit stalled = 0, done = 0;
    string r;
    r = $sformatf("r%0d", rnd);
    corrupt_idx = corrupt_at;
    for (int t = 0; t < 3000; t++) begin
      if (round_cnt == 8'(rnd + 1)) begin inc_cyc = cyc; done = 1; break; end
      if (abort_at >= 0 && nrd == abort_at) begin
        sys_rst_n = 1'b0;
        #1;
        chk_reset_vals({r, "_abort"});
        return;
      end
      if (fifo_wr_en && fifo_rd_en) proto_bad++;
      if (fifo_wr_en && fifo_full)  proto_bad++;
      if (fifo_rd_en && fifo_empty) proto_bad++;
      if (fifo_wr_en) begin
        if (fifo_wr_data !== 8'((nwr + rnd) & 255)) wbad++;
        if (nwr == 0)   chk({r, "_wr_first"}, fifo_wr_data, (rnd) & 255);
        if (nwr == 255) chk({r, "_wr_last"},  fifo_wr_data, (255 + rnd) & 255);
        if (stall_left > 0) stall_wr++;
        nwr++;
      end
      if (fifo_rd_en) begin
        if (nrd == corrupt_at) rdc = cyc;
        nrd++;
        last_rd = cyc;
      end
      if (!fifo_wr_en && !fifo_rd_en && nwr == 256 && nrd == 0) gap++;
      if (rdc >= 0 && cyc == rdc + 1) chk({r, "_err_at_cmp"}, err_flag, 0);
      if (rdc >= 0 && cyc == rdc + 2) chk({r, "_err_rise"},   err_flag, 1);
      @(posedge sys_clk); #1;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) force_full = 1'b0;
      end else if (stall_at >= 0 && !stalled && nwr == stall_at) begin
        force_full = 1'b1; stalled = 1; stall_left = 5;
      end
      @(negedge sys_clk); cyc++;
    end
    chk({r, "_done"},     done,    1);
    chk({r, "_nwr"},      nwr,     256);
    chk({r, "_nrd"},      nrd,     256);
    chk({r, "_wr_bad"},   wbad,    0);
    chk({r, "_settle"},   gap,     2);
    chk({r, "_drain"},    inc_cyc - last_rd, 2);
    chk({r, "_round"},    round_cnt, (rnd + 1) & 255);
    chk({r, "_err"},      err_flag, exp_err);
    chk({r, "_busy"},     busy,    1);
    if (stall_at >= 0) begin
      chk({r, "_stalled"},  stalled,  1);
      chk({r, "_stall_wr"}, stall_wr, 0);
    end
  endtask

  initial begin
    int idle_busy = 0;
    repeat (3) @(negedge sys_clk);
    chk_reset_vals("reset");
    sys_rst_n = 1'b1;
    run_round(0, -1, -1, -1, 0);
    run_round(1, -1, -1, -1, 0);
    run_round(2, 100, -1, -1, 0);
    run_round(3, -1, 37, -1, 1);
    run_round(4, -1, -1, -1, 1);
    run_round(5, -1, -1, 50, 0);
    repeat (2) @(negedge sys_clk);
    chk_reset_vals("rst_held");
    sys_rst_n = 1'b1;
    // FIFO still holds the aborted round's words, so the FSM must wait
    repeat (4) begin
      @(negedge sys_clk);
      if (busy || fifo_wr_en || fifo_rd_en) idle_busy++;
    end
    chk("idle_wait", idle_busy, 0);
    chk("idle_round", round_cnt, 0);
    @(posedge sys_clk); #1 flush = 1'b1;
    @(posedge sys_clk); #1 flush = 1'b0;
    @(negedge sys_clk);
    chk("idle_after_flush_busy", busy, 0);
    run_round(0, -1, -1, -1, 0);
    chk("protocol", proto_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_seq_ctrl.md
FIFO_SEQ_CTRL -- requirements
Module: fifo_seq_ctrl

Interface
REQ-001 Parameter DW, default 8, FIFO data width in bits.
REQ-002 Parameter DEPTH, default 256, FIFO depth in words, power of two.
REQ-003 Parameter SETTLE_CYC, default 2, idle cycles between the last write and the first read, covering the FIFO flag lag.
REQ-004 Port sys_clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-005 Port sys_rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-006 Port fifo_full  in  1  FIFO full flag.
REQ-007 Port fifo_empty  in  1  FIFO empty flag.
REQ-008 Port fifo_rd_data  in  DW  FIFO read data, valid the cycle after fifo_rd_en (normal-mode show-ahead off).
REQ-009 Port fifo_wr_en  out  1  FIFO write strobe.
REQ-010 Port fifo_wr_data  out  DW  FIFO write data.
REQ-011 Port fifo_rd_en  out  1  FIFO read strobe.
REQ-012 Port err_flag  out  1  sticky read-compare mismatch.
REQ-013 Port round_cnt  out  8  count of completed write/read rounds, wraps 255 -> 0.
REQ-014 Port busy  out  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL use the states IDLE, WRITE, SETTLE, READ, DRAIN.
REQ-016 IDLE -> WRITE SHALL occur on the first cycle after reset release when fifo_empty=1; otherwise the FSM SHALL stay in IDLE.
REQ-017 In WRITE, fifo_wr_en SHALL be 1 in a cycle only when fifo_full=0, with fifo_wr_data = (wr_idx + round_cnt) mod 2^DW.
REQ-018 wr_idx SHALL increment only on an accepted write (fifo_wr_en=1); fifo_full=1 SHALL stall the write with no data loss or skip.
REQ-019 After exactly DEPTH accepted writes, WRITE -> SETTLE, and fifo_wr_en SHALL be 0 from that cycle onward.
REQ-020 SETTLE SHALL last exactly SETTLE_CYC cycles and then go to READ.
REQ-021 In READ, fifo_rd_en SHALL be 1 in a cycle only when fifo_empty=0 and rd_idx < DEPTH; rd_idx SHALL increment per issued read.
REQ-022 Each fifo_rd_data sample, taken the cycle after its fifo_rd_en, SHALL be compared to (cmp_idx + round_cnt) mod 2^DW; cmp_idx SHALL increment per compare.
REQ-023 After DEPTH reads are issued, READ -> DRAIN; DRAIN SHALL complete the final compare in one cycle, then increment round_cnt and go to WRITE with wr_idx=rd_idx=cmp_idx=0.
REQ-024 A mismatch SHALL set err_flag on the cycle after the compare; err_flag SHALL stay set until reset.
REQ-025 fifo_wr_en and fifo_rd_en SHALL never be 1 in the same cycle.
REQ-026 Index counters SHALL be clog2(DEPTH)+1 bits so that the value DEPTH is representable; addition in the data pattern SHALL truncate to DW bits.
REQ-027 fifo_empty rising early during READ (rd_idx < DEPTH) SHALL stall reads without error; reads SHALL resume when fifo_empty falls.

Reset
REQ-028 On sys_rst_n=0 the FSM SHALL enter IDLE asynchronously; fifo_wr_en=0, fifo_rd_en=0, fifo_wr_data=0, err_flag=0, round_cnt=0, busy=0, and all indices=0.
REQ-029 Reset asserted mid-WRITE or mid-READ SHALL abort the round; round_cnt SHALL not increment.

Structure
REQ-030 Package fifo_seq_pkg SHALL hold the state encoding and the default DW/DEPTH/SETTLE_CYC constants.
REQ-031 The compare path (delayed rd_en, expected-value counter, sticky err_flag) SHALL be the sub-module fifo_rd_check.

Verification
REQ-032 Reset release with an ideal FIFO model (DW=8, DEPTH=256) -> 256 writes with data 0..255, 2 settle cycles, 256 reads, round_cnt=1, err_flag=0.
REQ-033 Second round -> write data 1,2,..,255,0; round_cnt=2; err_flag=0.
REQ-034 Model forces fifo_full=1 for 5 cycles at wr_idx=100 -> no fifo_wr_en during the stall, data resumes at 100 with no gap or duplicate.
REQ-035 Model corrupts read word 37 (XOR 0x01) -> err_flag rises one cycle after that compare and stays 1 through later rounds.
REQ-036 sys_rst_n pulsed low at rd_idx=50 -> all outputs at reset values immediately; after release the FSM waits in IDLE until fifo_empty=1, and round_cnt=0.
REQ-037 Assertion across all tests -> fifo_wr_en and fifo_rd_en never high together, no write while full, and no read while empty.
